// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async FIFO (rclk domain).
// Pops one DWIDTH-bit entry per cycle while the FIFO is non-empty. Packs LANES
// consecutive entries, first popped in the low lane, into one word on a
// valid/ready port. A full word waits in the assembly register while the output
// register is occupied.
// Optional feature macro: FLUSH_TIMEOUT_EN. When it is defined, a partial word
// is flushed after TIMEOUT idle cycles, and out_be marks only the filled lanes.
module fifo_rd_packer #(
  parameter int DWIDTH  = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      rclk,
  input  logic                      reset_L,
  input  logic                      empty,
  output logic                      pop,
  input  logic [DWIDTH-1:0]         rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DWIDTH*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_be,
  output logic [15:0]               words_out
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_t;

  state_t                    state;
  logic [IDXW-1:0]           idx;
  logic [DWIDTH*LANES-1:0]   asm_data;
  logic [DWIDTH*LANES-1:0]   full_word;
  logic                      out_free;
  logic                      xfer;
  logic                      flush_due;
  logic [LANES-1:0]          partial_be;

  // Pop only while filling and data is present; held low during reset.
  assign pop      = reset_L && (state == ST_FILL) && !empty;
  assign out_free = !out_valid || out_ready;
  assign xfer     = out_valid && out_ready;

  // Completed word as it will look once this cycle's entry lands in the top lane.
  always_comb begin
    full_word = asm_data;
    full_word[(LANES-1)*DWIDTH +: DWIDTH] = rdata;
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] idle_cnt;

  // The flush fires on the edge that completes the TIMEOUT-th idle cycle.
  assign flush_due = (state == ST_FILL) && (idx != '0) && !pop &&
                     (int'(idle_cnt) >= TIMEOUT - 1);

  // Mask of the lanes already filled in the partial word.
  always_comb begin
    partial_be = '0;
    for (int i = 0; i < LANES; i++) begin
      partial_be[i] = (i < int'(idx));
    end
  end

  // Idle counter: runs while a partial word sits without pops, saturating while the flush is blocked.
  always_ff @(posedge rclk or negedge reset_L) begin
    if (!reset_L) begin
      idle_cnt <= '0;
    end else if ((state != ST_FILL) || (idx == '0) || pop || (flush_due && out_free)) begin
      idle_cnt <= '0;
    end else if (int'(idle_cnt) < TIMEOUT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush_due  = 1'b0;
  assign partial_be = '1;
`endif

  // Packing FSM: fills the assembly register, hands words to the output register, counts transfers.
  always_ff @(posedge rclk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_FILL;
      idx       <= '0;
      asm_data  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
      words_out <= '0;
    end else begin
      if (xfer) begin
        words_out <= words_out + 16'd1;
        out_valid <= 1'b0;
      end
      case (state)
        ST_FILL: begin
          if (pop) begin
            if (idx == LAST_IDX) begin
              if (out_free) begin
                out_data  <= full_word;
                out_be    <= '1;
                out_valid <= 1'b1;
                asm_data  <= '0;
                idx       <= '0;
              end else begin
                asm_data[(LANES-1)*DWIDTH +: DWIDTH] <= rdata;
                state <= ST_WAIT;
              end
            end else begin
              asm_data[int'(idx)*DWIDTH +: DWIDTH] <= rdata;
              idx <= idx + 1'b1;
            end
          end else if (flush_due && out_free) begin
            out_data  <= asm_data;
            out_be    <= partial_be;
            out_valid <= 1'b1;
            asm_data  <= '0;
            idx       <= '0;
          end
        end
        ST_WAIT: begin
          if (out_ready) begin
            out_data  <= asm_data;
            out_be    <= '1;
            out_valid <= 1'b1;
            asm_data  <= '0;
            idx       <= '0;
            state     <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule
